inst_mem_resp: RTL and testbench
================================

# inst_mem_resp

Instruction-memory responder: the memory end of the core's instruction-fetch interface. It accepts fetch requests (word address) through a valid/ready handshake, waits a configurable number of cycles, and returns the instruction word with its address through a valid/ready response channel. It supports flush on jump and a program-load write port. It sits between the fetch unit and the instruction storage, replacing the direct ROM hookup.

## Interface
- `ADDR_W`, 32, width of the byte address.
- `DATA_W`, 32, instruction word width.
- `DEPTH`, 4096, number of words; power of two.
- `WAIT_CYCLES`, 1, extra wait states per access; legal range 0..15.
- `NOP_INST`, 32'h00000013, word returned on error.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_addr`  in  ADDR_W  byte address of the fetch.
- `flush`  in  1  jump or flush; discards any in-flight access.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  fetch side accepts the response.
- `rsp_data`  out  DATA_W  instruction word.
- `rsp_addr`  out  ADDR_W  address belonging to `rsp_data`.
- `rsp_err`  out  1  misaligned or out-of-range fetch.
- `wr_en`  in  1  program-load write strobe.
- `wr_addr`  in  ADDR_W  byte address of the write.
- `wr_data`  in  DATA_W  write word.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready` = !flush.
  - On `req_valid & req_ready`: latch `req_addr`.
  - If `WAIT_CYCLES==0`, sample memory this cycle and go to RESP.
  - Otherwise load wait counter = WAIT_CYCLES-1 and go to WAIT.
- **WAIT:**
  - Counter decrements each cycle.
  - When the counter is 0, sample memory and go to RESP.
  - `req_ready` = 0.
- **RESP:**
  - `rsp_valid` = 1.
  - `rsp_data`/`rsp_addr`/`rsp_err` are held stable until `rsp_ready`.
  - On `rsp_ready`, return to IDLE.
  - Pass-through accept: `req_ready` = `rsp_ready & !flush` in RESP. A request accepted together with the response retirement goes straight into WAIT, or into RESP when `WAIT_CYCLES==0`.
- **Flush:** synchronous. From any state, the next state is IDLE, `rsp_valid` drops the next cycle, and the latched access is discarded. A request presented in the flush cycle is not accepted. Flush in RESP with `rsp_ready=1` does not count as a handshake.
- **Errors:**
  - Misaligned (`req_addr[1:0]!=0`) or out-of-range (`req_addr[ADDR_W-1:2] >= DEPTH`) gives `rsp_err=1` and `rsp_data=NOP_INST`.
  - Timing is the same as a normal access.
- **Write port:**
  - Independent of the FSM.
  - Word index = `wr_addr[log2(DEPTH)+1:2]`.
  - Misaligned or out-of-range writes are ignored.
  - A write to the word being sampled in the same cycle: the read returns the old word.
- **Reset:** memory contents are not reset.

## Timing
- **Reset values:** state IDLE, `rsp_valid`=0, `rsp_data`=NOP_INST, `rsp_addr`=0, `rsp_err`=0. `req_ready`=1 once `rst_n` is high and flush=0.
- **Latency:** request accepted at edge N gives `rsp_valid` high from cycle N+1+WAIT_CYCLES.
- **Back-to-back throughput:**
  - `WAIT_CYCLES=0` with `rsp_ready` held high: one response per cycle.
  - Otherwise: one response per WAIT_CYCLES+1 cycles.
- **Reset mid-operation:** reset asserted mid-access drops `rsp_valid` immediately (async). No response is produced for that access.
- `rsp_*` are registered outputs. `req_ready` is combinational from state, `rsp_ready` and `flush`.

## Structure
- **Shared defines file:**
  - `INST_ADDR_BUS` / `INST_DATA_BUS` widths.
  - `NOP_INST` constant.
  - FSM state encodings (2-bit).
- **Sub-module `inst_mem_array`:** DEPTH x DATA_W storage with one write port and one synchronous read port (read data registered on the sample cycle). Keeps the storage inferable as block RAM.
- **Top `inst_mem_resp`:** FSM, wait counter, address check, response registers.

## Test plan
- **Basic read, WAIT_CYCLES=1:** load word 0x00500093 at 0x8. Request 0x8 at edge 10 with `rsp_ready`=1 gives `rsp_valid` in cycle 12 with `rsp_data`=0x00500093, `rsp_addr`=0x8, `rsp_err`=0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid`. Data and address must stay stable, and `req_ready` must stay 0. Raising `rsp_ready` returns the FSM to IDLE next cycle.
- **Streaming, WAIT_CYCLES=0:** requests 0x0,0x4,0x8,0xC on consecutive cycles with `rsp_ready`=1 give four consecutive responses in order, no bubbles.
- **Flush:** flush one cycle after accepting 0x10 (WAIT_CYCLES=3). No response for 0x10. A request for 0x20 two cycles later returns the 0x20 word.
- **Errors:** requests to 0x6 and to DEPTH*4 give `rsp_err`=1 and `rsp_data`=0x00000013 with normal latency. A write to 0x6 leaves memory unchanged.
- **Read/write collision and reset:**
  - Write 0xDEADBEEF to 0x4 in the sample cycle of a read of 0x4: old word returned. The next read of 0x4 returns 0xDEADBEEF.
  - `rst_n` low during WAIT: `rsp_valid` 0 immediately and no response after release.

Source files
------------

// File: rtl/inst_mem_resp_pkg.sv
// Shared widths, constants and FSM encodings for the instruction-memory responder.
// Imported by the responder top and its storage array.
package inst_mem_resp_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_DATA_BUS = 32;

  localparam logic [INST_DATA_BUS-1:0] NOP_INST = 32'h0000_0013;

  // Wide enough for the largest legal wait-state setting (15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // The counter is loaded with the number of wait cycles still to go after the accept edge.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_cycles);
    if (wait_cycles == 0) begin
      return '0;
    end
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/inst_mem_resp_array.sv
// Instruction storage: one write port and one registered read port, shaped for block-RAM inference.
// A read and a write to the same word in one cycle return the old word.
module inst_mem_array #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 12
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_mem_resp.sv
// Memory end of the instruction-fetch interface: request handshake, wait states,
// held response, flush, and a program-load write port into the storage array.
module inst_mem_resp #(
  parameter int unsigned       ADDR_W      = inst_mem_resp_pkg::INST_ADDR_BUS,
  parameter int unsigned       DATA_W      = inst_mem_resp_pkg::INST_DATA_BUS,
  parameter int unsigned       DEPTH       = 4096,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] NOP_INST    = inst_mem_resp_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  import inst_mem_resp_pkg::*;

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              nop_sel_q;

  logic              accept;
  logic              sample_en;
  logic              sample_err_d;
  logic [ADDR_W-1:0] sample_addr_d;
  logic [IDX_W-1:0]  rd_idx_d;
  logic [IDX_W-1:0]  wr_idx_d;
  logic              rd_en;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] word_ext;
    word_ext = {3'b000, a[ADDR_W-1:2]};
    return (a[1:0] != 2'b00) || (word_ext >= (ADDR_W+1)'(DEPTH));
  endfunction

  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = !flush;
      ST_RESP: req_ready = rsp_ready & !flush;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid & req_ready;

  // Zero wait states read straight from the incoming address on the accept edge.
  assign sample_addr_d = (state_q == ST_WAIT) ? addr_q : req_addr;
  assign sample_en     = !flush &
                         ((accept && (WAIT_CYCLES == 0)) ||
                          ((state_q == ST_WAIT) && (cnt_q == '0)));
  assign sample_err_d  = addr_bad(sample_addr_d);
  assign rd_en         = sample_en & !sample_err_d;
  assign rd_idx_d      = sample_addr_d[IDX_W+1:2];

  assign wr_ok    = wr_en & !addr_bad(wr_addr);
  assign wr_idx_d = wr_addr[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      nop_sel_q   <= 1'b1;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= req_addr;
        cnt_q       <= CNT_LOAD;
        state_q     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        rsp_valid_q <= (WAIT_CYCLES == 0);
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_WAIT: begin
            if (cnt_q == '0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          ST_RESP: begin
            if (rsp_ready) begin
              state_q     <= ST_IDLE;
              rsp_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        endcase
      end
      // Error and NOP select are captured with the sample so they stay aligned with the read data.
      if (sample_en) begin
        rsp_err_q <= sample_err_d;
        nop_sel_q <= sample_err_d;
      end
    end
  end

  inst_mem_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .wr_en_i  (wr_ok),
    .wr_idx_i (wr_idx_d),
    .wr_data_i(wr_data),
    .rd_en_i  (rd_en),
    .rd_idx_i (rd_idx_d),
    .rd_data_o(rd_data)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = addr_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = nop_sel_q ? NOP_INST : rd_data;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three instances (0, 1 and 3 wait states) share stimulus,
// one is selected per scenario and checked through a response scoreboard.
module tb_inst_mem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic [2:0]  req_ready_v;
  logic [2:0]  rsp_valid_v;
  logic [2:0]  rsp_err_v;
  logic [31:0] rsp_data_v [0:2];
  logic [31:0] rsp_addr_v [0:2];

  logic [1:0]  sel = 2'd0;
  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_data_s, rsp_addr_s;

  exp_t        exp_q [$];
  int          rsp_cyc_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_edge = 0;
  logic [31:0] model [4096];

  inst_mem_resp #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_v[0]),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_v[0]), .rsp_addr(rsp_addr_v[0]), .rsp_err(rsp_err_v[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  inst_mem_resp #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_v[1]),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_v[1]), .rsp_addr(rsp_addr_v[1]), .rsp_err(rsp_err_v[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  inst_mem_resp #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_v[2]),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_v[2]), .rsp_addr(rsp_addr_v[2]), .rsp_err(rsp_err_v[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  assign req_ready_s = req_ready_v[sel];
  assign rsp_valid_s = rsp_valid_v[sel];
  assign rsp_err_s   = rsp_err_v[sel];
  assign rsp_data_s  = rsp_data_v[sel];
  assign rsp_addr_s  = rsp_addr_v[sel];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every retired response of the selected instance is checked against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid_s && rsp_ready && !flush) begin
      n_vec++;
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp: got addr=%h data=%h err=%b, required no response",
                 rsp_addr_s, rsp_data_s, rsp_err_s);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_addr_s, rsp_data_s, rsp_err_s} !== {e.addr, e.data, e.err}) begin
          n_err++;
          $display("FAIL rsp_compare: got addr=%h data=%h err=%b, required addr=%h data=%h err=%b",
                   rsp_addr_s, rsp_data_s, rsp_err_s, e.addr, e.data, e.err);
        end else begin
          $display("rsp addr=%h data=%h err=%b at cycle %0d", rsp_addr_s, rsp_data_s, rsp_err_s, cyc);
        end
      end
    end
  end

  function automatic exp_t mk_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.err  = (a[1:0] != 2'b00) || (a[31:14] != '0);
    e.data = e.err ? NOP : model[a[13:2]];
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    rsp_cyc_q.delete();
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (a[1:0] == 2'b00 && a[31:14] == '0) model[a[13:2]] = d;
  endtask

  task automatic send_req(input logic [31:0] a, input bit push);
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (req_ready_s) begin
        done = 1'b1;
        acc_edge = cyc + 1;
        if (push) exp_q.push_back(mk_exp(a));
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL req_accept: addr=%h not accepted within 64 cycles, required acceptance", a);
    end else begin
      $display("req addr=%h accepted at edge %0d", a, acc_edge);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    sel = 2'd0;
    do_reset();
    @(negedge clk);
    n_vec++; if (rsp_valid_s !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid_s); end
    n_vec++; if (rsp_data_s !== NOP) begin n_err++; $display("FAIL reset_rsp_data: got %h, required %h", rsp_data_s, NOP); end
    n_vec++; if (rsp_addr_s !== 32'h0) begin n_err++; $display("FAIL reset_rsp_addr: got %h, required 0", rsp_addr_s); end
    n_vec++; if (rsp_err_s !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err_s); end
    n_vec++; if (req_ready_s !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b, required 1", req_ready_s); end
    $display("reset state checked");
  endtask

  task automatic test_basic_read();
    int lat;
    sel = 2'd0;
    do_reset();
    rsp_ready = 1'b1;
    write_word(32'h8, 32'h0050_0093);
    send_req(32'h8, 1'b1);
    wait_drain();
    lat = (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - acc_edge : -1;
    n_vec++;
    if (lat != 1) begin n_err++; $display("FAIL basic_latency: got %0d, required 1", lat); end
  endtask

  task automatic test_backpressure();
    bit seen;
    sel = 2'd0;
    do_reset();
    rsp_ready = 1'b0;
    send_req(32'h8, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid_s;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL bp_valid: rsp_valid never rose, required 1"); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({rsp_valid_s, rsp_data_s, rsp_addr_s, req_ready_s} !== {1'b1, 32'h0050_0093, 32'h8, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h addr=%h req_ready=%b, required 1/00500093/00000008/0",
                 k, rsp_valid_s, rsp_data_s, rsp_addr_s, req_ready_s);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if ({rsp_valid_s, req_ready_s} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_release: got valid=%b req_ready=%b, required 0/1", rsp_valid_s, req_ready_s);
    end
    wait_drain();
  endtask

  task automatic test_streaming();
    int first;
    sel = 2'd1;
    do_reset();
    rsp_ready = 1'b1;
    write_word(32'h0, 32'h0010_0093);
    write_word(32'h4, 32'h0020_0113);
    write_word(32'h8, 32'h0030_0193);
    write_word(32'hC, 32'h0040_0213);
    first = 0;
    for (int k = 0; k < 4; k++) begin
      send_req(32'(k * 4), 1'b1);
      if (k == 0) first = acc_edge;
    end
    wait_drain();
    n_vec++;
    if (rsp_cyc_q.size() != 4) begin
      n_err++;
      $display("FAIL stream_count: got %0d, required 4", rsp_cyc_q.size());
    end else begin
      n_vec++;
      if (rsp_cyc_q[0] - first != 0) begin n_err++; $display("FAIL stream_latency: got %0d, required 0", rsp_cyc_q[0] - first); end
      for (int k = 1; k < 4; k++) begin
        n_vec++;
        if (rsp_cyc_q[k] - rsp_cyc_q[k-1] != 1) begin
          n_err++;
          $display("FAIL stream_gap[%0d]: got %0d, required 1", k, rsp_cyc_q[k] - rsp_cyc_q[k-1]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int lat;
    sel = 2'd2;
    do_reset();
    rsp_ready = 1'b1;
    write_word(32'h10, 32'h00A0_0513);
    write_word(32'h20, 32'h00B0_0593);
    send_req(32'h10, 1'b0);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h30;
    @(negedge clk);
    n_vec++;
    if (req_ready_s !== 1'b0) begin n_err++; $display("FAIL flush_req_ready: got %b, required 0", req_ready_s); end
    @(posedge clk);
    #1 flush = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    send_req(32'h20, 1'b1);
    wait_drain();
    repeat (8) @(posedge clk);
    #1;
    lat = (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - acc_edge : -1;
    n_vec++;
    if (lat != 3) begin n_err++; $display("FAIL flush_latency: got %0d, required 3", lat); end
    n_vec++;
    if (rsp_cyc_q.size() != 1) begin n_err++; $display("FAIL flush_rsp_count: got %0d, required 1", rsp_cyc_q.size()); end
  endtask

  task automatic test_errors();
    int lat;
    sel = 2'd0;
    do_reset();
    rsp_ready = 1'b1;
    send_req(32'h6, 1'b1);
    wait_drain();
    lat = (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - acc_edge : -1;
    n_vec++;
    if (lat != 1) begin n_err++; $display("FAIL err_misalign_latency: got %0d, required 1", lat); end
    rsp_cyc_q.delete();
    send_req(32'h4000, 1'b1);
    wait_drain();
    lat = (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - acc_edge : -1;
    n_vec++;
    if (lat != 1) begin n_err++; $display("FAIL err_range_latency: got %0d, required 1", lat); end
    write_word(32'h6, 32'hFFFF_FFFF);
    write_word(32'h4000, 32'hEEEE_EEEE);
    send_req(32'h4, 1'b1);
    send_req(32'h0, 1'b1);
    wait_drain();
  endtask

  task automatic test_collision();
    sel = 2'd0;
    do_reset();
    rsp_ready = 1'b1;
    write_word(32'h4, 32'h1111_2222);
    send_req(32'h4, 1'b1);
    // Next edge is the sample edge for one wait state.
    wr_en = 1'b1;
    wr_addr = 32'h4;
    wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 wr_en = 1'b0;
    model[1] = 32'hDEAD_BEEF;
    wait_drain();
    send_req(32'h4, 1'b1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 2'd2;
    do_reset();
    rsp_ready = 1'b1;
    send_req(32'h20, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid_s !== 1'b0) begin n_err++; $display("FAIL rst_wait_valid: got %b, required 0", rsp_valid_s); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (rsp_cyc_q.size() != 0) begin n_err++; $display("FAIL rst_wait_rsp: got %0d responses, required 0", rsp_cyc_q.size()); end

    sel = 2'd0;
    do_reset();
    rsp_ready = 1'b0;
    send_req(32'h8, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid_s;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL rst_resp_pre: rsp_valid never rose, required 1"); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid_s !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b, required 0", rsp_valid_s); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (rsp_cyc_q.size() != 0) begin n_err++; $display("FAIL rst_resp_rsp: got %0d responses, required 0", rsp_cyc_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_backpressure();
    test_streaming();
    test_flush();
    test_errors();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
